// File: rtl/regfile_writeback_sink_if.sv
// Writeback/read bundle between the execute stage and the register-file sink.
// master = execute/writeback stage, slave = regfile_writeback_sink.
interface regfile_writeback_sink_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  wb_count;
  logic              wb_busy;

  modport master (
    output wb_valid, wb_addr, wb_data, rd_addr,
    input  wb_ready, rd_data, wb_count, wb_busy
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, rd_addr,
    output wb_ready, rd_data, wb_count, wb_busy
  );
endinterface

// File: rtl/regfile_writeback_sink.sv
// Register-file sink: in-order write buffer draining one entry per cycle into
// an R0-zero register array. Optional read bypass: define REGFILE_BYPASS_EN.
module regfile_writeback_sink #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_writeback_sink_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NREG  = 2 ** ADDR_W;

  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [ADDR_W-1:0] buf_addr_q [DEPTH];
  logic [DATA_W-1:0] buf_data_q [DEPTH];
  logic [DATA_W-1:0] regs_q     [NREG];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ready_q,  ready_d;
  logic             busy_q,   busy_d;
  logic             push_s;
  logic             pop_s;
  logic [DATA_W-1:0] rd_data_s;

  // Handshake and occupancy next-state; ready/busy are registered from count_d.
  always_comb begin
    push_s   = bus.wb_valid && ready_q;
    pop_s    = busy_q;
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != CNT_FULL);
    busy_d  = (count_d != {CNT_W{1'b0}});
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  // Write-buffer storage; reset discards any uncommitted entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_addr_q[i] <= ADDR_ZERO;
        buf_data_q[i] <= DATA_ZERO;
      end
    end else if (push_s) begin
      buf_addr_q[wr_ptr_q] <= bus.wb_addr;
      buf_data_q[wr_ptr_q] <= bus.wb_data;
    end else begin
      buf_addr_q[wr_ptr_q] <= buf_addr_q[wr_ptr_q];
      buf_data_q[wr_ptr_q] <= buf_data_q[wr_ptr_q];
    end
  end

  // Register array: head entry commits every cycle the buffer is non-empty; R0 never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= DATA_ZERO;
      end
    end else if (pop_s && (buf_addr_q[rd_ptr_q] != ADDR_ZERO)) begin
      regs_q[buf_addr_q[rd_ptr_q]] <= buf_data_q[rd_ptr_q];
    end else begin
      regs_q[0] <= DATA_ZERO;
    end
  end

  // Asynchronous read port; bypass scans oldest to newest so the newest match wins.
  always_comb begin
    rd_data_s = DATA_ZERO;
    if (bus.rd_addr == ADDR_ZERO) begin
      rd_data_s = DATA_ZERO;
    end else begin
      rd_data_s = regs_q[bus.rd_addr];
`ifdef REGFILE_BYPASS_EN
      for (int i = 0; i < DEPTH; i++) begin
        rd_data_s = ((CNT_W'(i) < count_q) &&
                     (buf_addr_q[rd_ptr_q + PTR_W'(i)] == bus.rd_addr))
                    ? buf_data_q[rd_ptr_q + PTR_W'(i)] : rd_data_s;
      end
`else
      rd_data_s = regs_q[bus.rd_addr];
`endif
    end
  end

  assign bus.wb_ready = ready_q;
  assign bus.wb_busy  = busy_q;
  assign bus.wb_count = count_q;
  assign bus.rd_data  = rd_data_s;
endmodule
